// File: rtl/sprite_fetch_unit_if.sv
// Sprite fetch bus: frame control, scan position, sprite ROM port and pixel output.
interface sprite_fetch_unit_if #(
    parameter int ADDR_W = 15
) ();

    logic              frame_start;
    logic [9:0]        sprite_x;
    logic [9:0]        sprite_y;
    logic              face_left;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              pix_valid_in;
    logic [ADDR_W-1:0] read_address;
    logic [23:0]       rom_data;
    logic [23:0]       pixel_out;
    logic              pixel_on;
    logic              pixel_valid_out;
    logic [11:0]       opaque_count;

    // Driver side: video timing, sprite position and the ROM model
    modport master (
        output frame_start, sprite_x, sprite_y, face_left,
        output DrawX, DrawY, pix_valid_in, rom_data,
        input  read_address, pixel_out, pixel_on, pixel_valid_out, opaque_count
    );

    // Fetch unit side
    modport slave (
        input  frame_start, sprite_x, sprite_y, face_left,
        input  DrawX, DrawY, pix_valid_in, rom_data,
        output read_address, pixel_out, pixel_on, pixel_valid_out, opaque_count
    );

endinterface

// File: rtl/sprite_fetch_unit.sv
// Sprite fetch unit: maps the scan position onto a sprite ROM address, hides the
// one-cycle ROM latency, keys out the transparent colour and counts opaque pixels
// per frame. Three-stage pipeline, one pixel per clock, all outputs registered.
module sprite_fetch_unit #(
    parameter int          SPR_W     = 30,
    parameter int          SPR_H     = 29,
    parameter int          ADDR_W    = 15,
    parameter logic [23:0] KEY_COLOR = 24'hFFFFFF
) (
    input logic                Clk,
    input logic                Reset,
    sprite_fetch_unit_if.slave bus
);

    localparam logic signed [10:0] SPR_W_S = 11'(SPR_W);
    localparam logic signed [10:0] SPR_H_S = 11'(SPR_H);
    localparam logic [11:0]        CNT_MAX = 12'hFFF;

    // Shadow copies of the sprite placement, refreshed only at frame_start
    logic [9:0]        shadowX_q, shadowX_d;
    logic [9:0]        shadowY_q, shadowY_d;
    logic              shadowFace_q, shadowFace_d;

    // Stage 1: address, hit and valid
    logic [ADDR_W-1:0] readAddress_q, readAddress_d;
    logic              hitD1_q, hitD1_d;
    logic              validD1_q, validD1_d;

    // Stage 2: hit and valid aligned with the ROM data
    logic              hitD2_q, hitD2_d;
    logic              validD2_q, validD2_d;

    // Stage 3: keyed pixel output
    logic              pixelOn_q, pixelOn_d;
    logic [23:0]       pixelOut_q, pixelOut_d;
    logic              pixelValid_q, pixelValid_d;

    // Opaque pixel counters
    logic [11:0]       runCnt_q, runCnt_d;
    logic [11:0]       opaqueCnt_q, opaqueCnt_d;

    // Offsets of the scan position into the sprite box
    logic signed [10:0] dx, dy;
    logic signed [10:0] col;
    logic               hit;
    logic [ADDR_W-1:0]  addrCalc;

    // Shadow latch: new placement only takes effect at the frame boundary
    always_comb begin
        shadowX_d    = shadowX_q;
        shadowY_d    = shadowY_q;
        shadowFace_d = shadowFace_q;
        if (bus.frame_start) begin
            shadowX_d    = bus.sprite_x;
            shadowY_d    = bus.sprite_y;
            shadowFace_d = bus.face_left;
        end
    end

    // Stage 1 address math; signed offsets so positions left of or above the sprite never hit
    always_comb begin
        dx       = $signed({1'b0, bus.DrawX}) - $signed({1'b0, shadowX_q});
        dy       = $signed({1'b0, bus.DrawY}) - $signed({1'b0, shadowY_q});
        hit      = bus.pix_valid_in && !dx[10] && (dx < SPR_W_S) && !dy[10] && (dy < SPR_H_S);
        col      = shadowFace_q ? dx : (SPR_W_S - 11'sd1 - dx);
        addrCalc = ADDR_W'($unsigned(dy)) * ADDR_W'(SPR_W) + ADDR_W'($unsigned(col));
        readAddress_d = hit ? addrCalc : '0;
        hitD1_d       = hit;
        validD1_d     = bus.pix_valid_in;
    end

    // Stages 2 and 3: delay qualifiers past the ROM, then apply transparency keying
    always_comb begin
        hitD2_d      = hitD1_q;
        validD2_d    = validD1_q;
        pixelOn_d    = hitD2_q && (bus.rom_data != KEY_COLOR);
        pixelOut_d   = pixelOn_d ? bus.rom_data : 24'h0;
        pixelValid_d = validD2_q;
    end

    // Opaque counter: saturating running count, snapshotted and restarted at frame_start
    always_comb begin
        runCnt_d    = runCnt_q;
        opaqueCnt_d = opaqueCnt_q;
        if (bus.frame_start) begin
            opaqueCnt_d = runCnt_q;
            runCnt_d    = pixelOn_q ? 12'd1 : 12'd0;
        end else if (pixelOn_q && (runCnt_q != CNT_MAX)) begin
            runCnt_d = runCnt_q + 12'd1;
        end
    end

    // State registers; reset flushes the whole pipeline and restores a left-facing shadow
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shadowX_q     <= '0;
            shadowY_q     <= '0;
            shadowFace_q  <= 1'b1;
            readAddress_q <= '0;
            hitD1_q       <= 1'b0;
            validD1_q     <= 1'b0;
            hitD2_q       <= 1'b0;
            validD2_q     <= 1'b0;
            pixelOn_q     <= 1'b0;
            pixelOut_q    <= '0;
            pixelValid_q  <= 1'b0;
            runCnt_q      <= '0;
            opaqueCnt_q   <= '0;
        end else begin
            shadowX_q     <= shadowX_d;
            shadowY_q     <= shadowY_d;
            shadowFace_q  <= shadowFace_d;
            readAddress_q <= readAddress_d;
            hitD1_q       <= hitD1_d;
            validD1_q     <= validD1_d;
            hitD2_q       <= hitD2_d;
            validD2_q     <= validD2_d;
            pixelOn_q     <= pixelOn_d;
            pixelOut_q    <= pixelOut_d;
            pixelValid_q  <= pixelValid_d;
            runCnt_q      <= runCnt_d;
            opaqueCnt_q   <= opaqueCnt_d;
        end
    end

    assign bus.read_address    = readAddress_q;
    assign bus.pixel_on        = pixelOn_q;
    assign bus.pixel_out       = pixelOut_q;
    assign bus.pixel_valid_out = pixelValid_q;
    assign bus.opaque_count    = opaqueCnt_q;

endmodule

// File: tb/tb_sprite_fetch_unit.sv
// Directed testbench for sprite_fetch_unit with a registered sprite ROM model.
module tb_sprite_fetch_unit;

    logic Clk = 1'b0;
    logic Reset;

    int checks   = 0;
    int failures = 0;

    logic [14:0] capAddr;
    logic        capOn;
    logic [23:0] capOut;
    logic        capValid;

    logic [23:0] romMem [0:869];

    sprite_fetch_unit_if #(.ADDR_W(15)) bus ();

    sprite_fetch_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Free-running clock, period 10
    always #5 Clk = ~Clk;

    // Sprite ROM model with one-cycle registered read
    always @(posedge Clk) begin
        bus.rom_data <= (bus.read_address < 15'd870) ? romMem[bus.read_address] : 24'h0;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic v);
        bus.DrawX        = x;
        bus.DrawY        = y;
        bus.pix_valid_in = v;
    endtask

    // One isolated sample: address captured at t+1, pixel outputs at t+3
    task automatic runPixel(input logic [9:0] x, input logic [9:0] y, input logic v);
        applyStimulus(x, y, v);
        tick();
        capAddr = bus.read_address;
        applyStimulus(10'd0, 10'd0, 1'b0);
        tick();
        tick();
        capOn    = bus.pixel_on;
        capOut   = bus.pixel_out;
        capValid = bus.pixel_valid_out;
    endtask

    task automatic startFrame(input logic [9:0] x, input logic [9:0] y, input logic f);
        bus.sprite_x    = x;
        bus.sprite_y    = y;
        bus.face_left   = f;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic fillRom(input int nOpaque);
        for (int i = 0; i < 870; i++)
            romMem[i] = (i < nOpaque) ? (24'h010000 + 24'(i)) : 24'hFFFFFF;
    endtask

    // Continuous valid scan over the sprite box, then flush the pipeline
    task automatic scanBox(input logic [9:0] x0, input logic [9:0] y0, input int reps);
        for (int r = 0; r < reps; r++)
            for (int yy = 0; yy < 29; yy++)
                for (int xx = 0; xx < 30; xx++) begin
                    applyStimulus(x0 + 10'(xx), y0 + 10'(yy), 1'b1);
                    tick();
                end
        applyStimulus(10'd0, 10'd0, 1'b0);
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        bus.frame_start = 1'b1;
        bus.sprite_x = 10'd55;
        bus.sprite_y = 10'd0;
        bus.face_left = 1'b0;
        applyStimulus(10'd0, 10'd0, 1'b0);
        tick();
        tick();
        Reset = 1'b0;
        bus.frame_start = 1'b0;
        checks++;
        if (bus.read_address !== 15'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.read_address); end
        checks++;
        if (bus.pixel_on !== 1'b0) begin failures++; $display("FAIL reset_on got=%b exp=0", bus.pixel_on); end
        checks++;
        if (bus.pixel_out !== 24'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", bus.pixel_out); end
        checks++;
        if (bus.pixel_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.pixel_valid_out); end
        checks++;
        if (bus.opaque_count !== 12'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.opaque_count); end
        // shadow must be x=0,y=0,face=1 despite frame_start during reset
        runPixel(10'd1, 10'd0, 1'b1);
        checks++;
        if (capAddr !== 15'd1) begin failures++; $display("FAIL reset_shadow got=%0d exp=1", capAddr); end
    endtask

    task automatic test_address;
        startFrame(10'd100, 10'd200, 1'b1);
        runPixel(10'd100, 10'd200, 1'b1);
        checks++;
        if (capAddr !== 15'd0) begin failures++; $display("FAIL addr_origin got=%0d exp=0", capAddr); end
        checks++;
        if (capValid !== 1'b1) begin failures++; $display("FAIL valid_out got=%b exp=1", capValid); end
        runPixel(10'd129, 10'd228, 1'b1);
        checks++;
        if (capAddr !== 15'd869) begin failures++; $display("FAIL addr_last got=%0d exp=869", capAddr); end
        runPixel(10'd105, 10'd203, 1'b1);
        checks++;
        if (capAddr !== 15'd95) begin failures++; $display("FAIL addr_mid got=%0d exp=95", capAddr); end
    endtask

    task automatic test_mirror;
        startFrame(10'd100, 10'd200, 1'b0);
        runPixel(10'd100, 10'd200, 1'b1);
        checks++;
        if (capAddr !== 15'd29) begin failures++; $display("FAIL mirror_left got=%0d exp=29", capAddr); end
        runPixel(10'd129, 10'd200, 1'b1);
        checks++;
        if (capAddr !== 15'd0) begin failures++; $display("FAIL mirror_right got=%0d exp=0", capAddr); end
        runPixel(10'd100, 10'd201, 1'b1);
        checks++;
        if (capAddr !== 15'd59) begin failures++; $display("FAIL mirror_row1 got=%0d exp=59", capAddr); end
    endtask

    task automatic test_outside_and_key;
        fillRom(870);
        romMem[0] = 24'h3A7F10;
        startFrame(10'd100, 10'd200, 1'b1);
        runPixel(10'd130, 10'd200, 1'b1);
        checks++;
        if (capAddr !== 15'd0) begin failures++; $display("FAIL outside_x_addr got=%0d exp=0", capAddr); end
        checks++;
        if (capOn !== 1'b0 || capOut !== 24'h0) begin failures++; $display("FAIL outside_x_pix got=%b/%h exp=0/0", capOn, capOut); end
        runPixel(10'd110, 10'd199, 1'b1);
        checks++;
        if (capAddr !== 15'd0 || capOn !== 1'b0) begin failures++; $display("FAIL outside_y got=%0d/%b exp=0/0", capAddr, capOn); end
        runPixel(10'd101, 10'd200, 1'b0);
        checks++;
        if (capAddr !== 15'd0 || capOn !== 1'b0 || capValid !== 1'b0) begin failures++; $display("FAIL invalid got=%0d/%b/%b exp=0/0/0", capAddr, capOn, capValid); end
        runPixel(10'd100, 10'd200, 1'b1);
        checks++;
        if (capOn !== 1'b1 || capOut !== 24'h3A7F10) begin failures++; $display("FAIL opaque_pix got=%b/%h exp=1/3a7f10", capOn, capOut); end
        romMem[0] = 24'hFFFFFF;
        runPixel(10'd100, 10'd200, 1'b1);
        checks++;
        if (capOn !== 1'b0 || capOut !== 24'h0) begin failures++; $display("FAIL key_pix got=%b/%h exp=0/0", capOn, capOut); end
    endtask

    task automatic test_shadow;
        startFrame(10'd100, 10'd200, 1'b1);
        bus.sprite_x = 10'd300;
        runPixel(10'd101, 10'd200, 1'b1);
        checks++;
        if (capAddr !== 15'd1) begin failures++; $display("FAIL shadow_hold got=%0d exp=1", capAddr); end
        startFrame(10'd300, 10'd200, 1'b1);
        runPixel(10'd301, 10'd200, 1'b1);
        checks++;
        if (capAddr !== 15'd1) begin failures++; $display("FAIL shadow_new got=%0d exp=1", capAddr); end
        runPixel(10'd100, 10'd200, 1'b1);
        checks++;
        if (capAddr !== 15'd0 || capOn !== 1'b0) begin failures++; $display("FAIL shadow_old_pos got=%0d/%b exp=0/0", capAddr, capOn); end
    endtask

    task automatic test_count;
        fillRom(500);
        startFrame(10'd100, 10'd200, 1'b1);
        scanBox(10'd100, 10'd200, 1);
        startFrame(10'd100, 10'd200, 1'b1);
        checks++;
        if (bus.opaque_count !== 12'd500) begin failures++; $display("FAIL count_500 got=%0d exp=500", bus.opaque_count); end
        fillRom(870);
        scanBox(10'd100, 10'd200, 1);
        startFrame(10'd100, 10'd200, 1'b1);
        checks++;
        if (bus.opaque_count !== 12'd870) begin failures++; $display("FAIL count_870 got=%0d exp=870", bus.opaque_count); end
        scanBox(10'd100, 10'd200, 6);
        startFrame(10'd100, 10'd200, 1'b1);
        checks++;
        if (bus.opaque_count !== 12'd4095) begin failures++; $display("FAIL count_sat got=%0d exp=4095", bus.opaque_count); end
    endtask

    task automatic test_reset_midflight;
        fillRom(870);
        startFrame(10'd100, 10'd200, 1'b0);
        applyStimulus(10'd100, 10'd200, 1'b1);
        tick();
        applyStimulus(10'd0, 10'd0, 1'b0);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (bus.pixel_on !== 1'b0) begin failures++; $display("FAIL midreset_on got=%b exp=0", bus.pixel_on); end
        checks++;
        if (bus.pixel_valid_out !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", bus.pixel_valid_out); end
        checks++;
        if (bus.opaque_count !== 12'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", bus.opaque_count); end
        tick();
        checks++;
        if (bus.pixel_on !== 1'b0) begin failures++; $display("FAIL midreset_stale got=%b exp=0", bus.pixel_on); end
        runPixel(10'd1, 10'd0, 1'b1);
        checks++;
        if (capAddr !== 15'd1) begin failures++; $display("FAIL midreset_face got=%0d exp=1", capAddr); end
    endtask

    initial begin
        bus.frame_start  = 1'b0;
        bus.sprite_x     = 10'd0;
        bus.sprite_y     = 10'd0;
        bus.face_left    = 1'b1;
        bus.DrawX        = 10'd0;
        bus.DrawY        = 10'd0;
        bus.pix_valid_in = 1'b0;
        Reset            = 1'b1;
        fillRom(870);
        test_reset();
        test_address();
        test_mirror();
        test_outside_and_key();
        test_shadow();
        test_count();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
